data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory slave for the multi-cycle RISC-V core. Accepts one load or
//   store at a time over a valid/ready request channel, performs the access
//   after a fixed LATENCY and presents the result on a valid/ready response
//   channel. Supports byte/half/word accesses (little-endian) with sign or
//   zero extension on loads, and rejects misaligned, out-of-range and
//   illegal-func3 accesses without side effects.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_we         1 = store, 0 = load
//   req_addr       byte address
//   req_wdata      store data (low byte/half used for SB/SH)
//   req_func3      RISC-V func3 size/sign encoding
//   resp_valid/ready response handshake (valid held until accepted)
//   resp_rdata     extended load data; 0 for stores and errors
//   resp_err       access rejected
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept;
  logic        do_access;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_func3;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_func3;
  logic        acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0] acc_word;

  logic [31:0] mem [DEPTH_WORDS];

  // Any of: out of range, misaligned half/word, or unsupported func3.
  function automatic logic access_err(input logic we, input logic [31:0] addr,
                                      input logic [2:0] f3);
    logic e;
    e = (addr[31:2] >= DEPTH_L);
    case (f3[1:0])
      2'd1:    if (addr[0])          e = 1'b1;
      2'd2:    if (addr[1:0] != 2'd0) e = 1'b1;
      default: ;
    endcase
    if (we) begin
      if (f3 > 3'd2) e = 1'b1;
    end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
      e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] r;
    r = word;
    case (f3)
      3'd0:    r[{lane, 3'b000} +: 8]      = wdata[7:0];
      3'd1:    r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      3'd2:    r = wdata;
      default: ;
    endcase
    return r;
  endfunction

  // With LATENCY=1 the access happens on the accepting edge, so the live
  // request inputs are used instead of the (not yet latched) copies.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_func3 = req_func3;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_func3 = lat_func3;
    end
    acc_err  = access_err(acc_we, acc_addr, acc_func3);
    acc_idx  = acc_addr[IDX_W+1:2];
    acc_word = mem[acc_idx];
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          do_access = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_func3  <= 3'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_func3 <= req_func3;
        cnt       <= CNT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // access stage: commit store or register load result
      if (do_access) begin
        resp_err <= acc_err;
        if (acc_err) begin
          resp_rdata <= 32'd0;
        end else if (acc_we) begin
          resp_rdata   <= 32'd0;
          mem[acc_idx] <= store_merge(acc_word, acc_wdata, acc_addr[1:0], acc_func3);
        end else begin
          resp_rdata <= load_extract(acc_word, acc_addr[1:0], acc_func3);
        end
      end
    end
  end

endmodule
